// File: rtl/mgia_timegen.sv
// MGIA raster timing generator: dot-clock enable, H/V sync, refresh/fetch windows,
// position counters and frame/line markers with a frame-synchronous 400/480-line mode.
module mgia_timegen #(
  parameter int   CW            = 10,
  parameter int   DOT_DIV       = 2,
  parameter int   H_TOTAL       = 800,
  parameter int   H_SYNC_START  = 16,
  parameter int   H_SYNC_END    = 112,
  parameter int   H_ACT_START   = 160,
  parameter int   H_ACT_END     = 800,
  parameter int   V_TOTAL       = 525,
  parameter int   V_SYNC_START  = 10,
  parameter int   V_SYNC_END    = 12,
  parameter int   V_ACT_START_A = 85,
  parameter int   V_ACT_END_A   = 485,
  parameter int   V_ACT_START_B = 45,
  parameter int   V_ACT_END_B   = 525,
  parameter logic HSYNC_POL     = 1'b0,
  parameter logic VSYNC_POL     = 1'b0
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          MODE_I,
  output logic          DOT_EN_O,
  output logic          HSYNC_O,
  output logic          VSYNC_O,
  output logic          VREN_O,
  output logic          VFEN_O,
  output logic          ODD_O,
  output logic          SOF_O,
  output logic          SOL_O,
  output logic [CW-1:0] HPOS_O,
  output logic [CW-1:0] VPOS_O,
  output logic          MODE_O
);

  localparam int CW1 = CW + 1;
  localparam int PW  = (DOT_DIV > 1) ? $clog2(DOT_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(DOT_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

  // Window bounds carry one extra bit so an END equal to 2^CW stays representable.
  localparam logic [CW:0] HS_S = CW1'(H_SYNC_START);
  localparam logic [CW:0] HS_E = CW1'(H_SYNC_END);
  localparam logic [CW:0] HA_S = CW1'(H_ACT_START);
  localparam logic [CW:0] HA_E = CW1'(H_ACT_END);
  localparam logic [CW:0] VS_S = CW1'(V_SYNC_START);
  localparam logic [CW:0] VS_E = CW1'(V_SYNC_END);
  localparam logic [CW:0] VA_S = CW1'(V_ACT_START_A);
  localparam logic [CW:0] VA_E = CW1'(V_ACT_END_A);
  localparam logic [CW:0] VB_S = CW1'(V_ACT_START_B);
  localparam logic [CW:0] VB_E = CW1'(V_ACT_END_B);

  logic [PW-1:0] pre;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  logic          mode;

  logic          tick;
  logic          h_wrap;
  logic          f_wrap;
  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;
  logic [CW-1:0] v_fetch;
  logic          mode_nxt;
  logic          hact_d;
  logic          hs_d;
  logic          vs_d;
  logic          ren_d;
  logic          fen_d;

  function automatic logic in_win(input logic [CW-1:0] n,
                                  input logic [CW:0]   lo,
                                  input logic [CW:0]   hi);
    return ({1'b0, n} >= lo) && ({1'b0, n} < hi);
  endfunction

  function automatic logic vact(input logic [CW-1:0] n, input logic m);
    return m ? in_win(n, VB_S, VB_E) : in_win(n, VA_S, VA_E);
  endfunction

  // Everything is decoded from the post-tick counter and mode values so the
  // registered outputs line up with HPOS_O/VPOS_O on the same edge.
  always_comb begin
    tick     = (pre == PRE_LAST);
    h_wrap   = (hcnt == H_LAST);
    f_wrap   = h_wrap && (vcnt == V_LAST);
    h_nxt    = h_wrap ? '0 : hcnt + 1'b1;
    v_nxt    = vcnt;
    if (h_wrap) begin
      v_nxt = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end
    mode_nxt = f_wrap ? MODE_I : mode;
    v_fetch  = (v_nxt == V_LAST) ? '0 : v_nxt + 1'b1;
    hact_d   = in_win(h_nxt, HA_S, HA_E);
    hs_d     = in_win(h_nxt, HS_S, HS_E) ? HSYNC_POL : ~HSYNC_POL;
    vs_d     = in_win(v_nxt, VS_S, VS_E) ? VSYNC_POL : ~VSYNC_POL;
    ren_d    = hact_d & vact(v_nxt, mode_nxt);
    fen_d    = hact_d & vact(v_fetch, mode_nxt);
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      pre      <= '0;
      hcnt     <= '0;
      vcnt     <= '0;
      mode     <= 1'b0;
      DOT_EN_O <= 1'b0;
      HSYNC_O  <= ~HSYNC_POL;
      VSYNC_O  <= ~VSYNC_POL;
      VREN_O   <= 1'b0;
      VFEN_O   <= 1'b0;
      ODD_O    <= 1'b1;
      SOF_O    <= 1'b0;
      SOL_O    <= 1'b0;
    end else begin
      pre      <= tick ? '0 : pre + 1'b1;
      DOT_EN_O <= tick;
      SOF_O    <= tick & f_wrap;
      SOL_O    <= tick & h_wrap;
      if (tick) begin
        hcnt    <= h_nxt;
        vcnt    <= v_nxt;
        mode    <= mode_nxt;
        HSYNC_O <= hs_d;
        VSYNC_O <= vs_d;
        VREN_O  <= ren_d;
        VFEN_O  <= fen_d;
        ODD_O   <= ~v_nxt[0];
      end
    end
  end

  assign HPOS_O = hcnt;
  assign VPOS_O = vcnt;
  assign MODE_O = mode;

endmodule
